// File: rtl/pwm_ramp_ctrl_if.sv
// Control bundle between a PWM ramp controller and its host/PWM counter side.
// The slave side is the controller; state is a debug view of the FSM.
interface pwm_ramp_ctrl_if #(parameter int W = 8);
    logic         start;
    logic         stop;
    logic         mode_down;
    logic [W-1:0] per_in;
    logic [W-1:0] tgt_cmp;
    logic [W-1:0] step;
    logic [W-1:0] cnt;
    logic         en;
    logic         down;
    logic [W-1:0] cmp;
    logic [W-1:0] per;
    logic         busy;
    logic         done;
    logic [1:0]   state;

    // Level-style controls: start/stop are sampled every cycle, no ready/ack;
    // done is a single-cycle pulse qualified by nothing else.
    modport slave (
        input  start, stop, mode_down, per_in, tgt_cmp, step, cnt,
        output en, down, cmp, per, busy, done, state
    );

    modport master (
        output start, stop, mode_down, per_in, tgt_cmp, step, cnt,
        input  en, down, cmp, per, busy, done, state
    );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Ramps a PWM compare value toward a target by a fixed step once per PWM
// period, holds it there, and ramps back to zero before shutting the counter off.
module pwm_ramp_ctrl #(
    parameter int W = 8
) (
    input logic            clk50m,
    input logic            rst_n,
    pwm_ramp_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t       state;
    logic         en_q;
    logic         down_q;
    logic         busy_q;
    logic         done_q;
    logic [W-1:0] cmp_q;
    logic [W-1:0] per_q;
    logic [W-1:0] tgt;
    logic [W-1:0] stp;
    logic         boundary;
    logic [W:0]   cmp_x;
    logic [W:0]   tgt_x;
    logic [W:0]   stp_x;
    logic [W:0]   ramp_next;
    logic [W-1:0] stop_next;

    assign boundary = en_q && ((!down_q && bus.cnt == per_q) || (down_q && bus.cnt == '0));

    // One extra bit keeps cmp +/- stp from wrapping before it is clamped to tgt.
    always_comb begin
        cmp_x     = {1'b0, cmp_q};
        tgt_x     = {1'b0, tgt};
        stp_x     = {1'b0, stp};
        ramp_next = tgt_x;
        if (stp_x != '0) begin
            if (cmp_x < tgt_x) begin
                if (tgt_x - cmp_x > stp_x) ramp_next = cmp_x + stp_x;
            end else if (cmp_x > tgt_x) begin
                if (cmp_x - tgt_x > stp_x) ramp_next = cmp_x - stp_x;
            end
        end
        stop_next = '0;
        if (stp != '0 && cmp_q > stp) stop_next = cmp_q - stp;
    end

    always_ff @(posedge clk50m) begin
        if (!rst_n) begin
            state  <= IDLE;
            en_q   <= 1'b0;
            down_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cmp_q  <= '0;
            per_q  <= '0;
            tgt    <= '0;
            stp    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop && bus.per_in != '0) begin
                        per_q  <= bus.per_in;
                        down_q <= bus.mode_down;
                        tgt    <= bus.tgt_cmp;
                        stp    <= bus.step;
                        cmp_q  <= '0;
                        en_q   <= 1'b1;
                        busy_q <= 1'b1;
                        state  <= RAMP;
                    end
                end
                RAMP: begin
                    if (bus.stop) begin
                        state <= STOP;
                    end else if (boundary) begin
                        cmp_q <= ramp_next[W-1:0];
                        if (ramp_next == tgt_x) begin
                            state  <= HOLD;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (bus.stop) begin
                        state  <= STOP;
                        busy_q <= 1'b1;
                    end else if (bus.start) begin
                        tgt <= bus.tgt_cmp;
                        stp <= bus.step;
                        // Re-targeting to the current value needs no ramp and no done.
                        if (bus.tgt_cmp != cmp_q) begin
                            state  <= RAMP;
                            busy_q <= 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (boundary) begin
                        if (cmp_q == '0) begin
                            en_q   <= 1'b0;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            cmp_q <= stop_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.en    = en_q;
    assign bus.down  = down_q;
    assign bus.cmp   = cmp_q;
    assign bus.per   = per_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.state = state;
endmodule
